// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with turnaround cycle
// Optional grant watchdog enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] done,
  input  logic       bus_handshake_1,
  input  logic       bus_handshake_2,
  input  logic       timeout_clr,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err,
  output logic       timeout_master
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state;
  logic   last_served;
  logic   cur;
  logic   pick;
  logic   finish;
  logic   unused;

  // grant is one-hot, so its upper bit is the owner's index
  assign cur    = grant[1];
  assign pick   = (req == 2'b11) ? ~last_served : req[1];
  assign finish = done[cur] | ~req[cur];

`ifdef BUS_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          hs2_q;
  logic          hs2_rise;
  logic          expired;

  assign unused   = bus_handshake_1;
  assign hs2_rise = bus_handshake_2 & ~hs2_q;
  assign expired  = (cnt == CNT_LAST);
`else
  assign unused         = ^{bus_handshake_1, bus_handshake_2, timeout_clr, (TIMEOUT_CYCLES > 0)};
  assign timeout_err    = 1'b0;
  assign timeout_master = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 2'b00;
      busy        <= 1'b0;
      last_served <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      timeout_err    <= 1'b0;
      timeout_master <= 1'b0;
      cnt            <= '0;
      hs2_q          <= 1'b0;
`endif
    end else begin
`ifdef BUS_TIMEOUT_EN
      hs2_q <= bus_handshake_2;
      // a timeout below overrides this clear when both land together
      if (timeout_clr) timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= GRANT;
            grant       <= pick ? 2'b10 : 2'b01;
            last_served <= pick;
            busy        <= 1'b1;
`ifdef BUS_TIMEOUT_EN
            cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (finish) begin
            state <= RELEASE;
            grant <= 2'b00;
          end
`ifdef BUS_TIMEOUT_EN
          else if (expired) begin
            state          <= RELEASE;
            grant          <= 2'b00;
            timeout_err    <= 1'b1;
            timeout_master <= cur;
          end else if (hs2_rise) begin
            cnt <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed table-driven bench for bus_arbiter (TIMEOUT_CYCLES=16)
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] done;
  logic       bus_handshake_1;
  logic       bus_handshake_2;
  logic       timeout_clr;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;
  logic       timeout_master;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .done            (done),
    .bus_handshake_1 (bus_handshake_1),
    .bus_handshake_2 (bus_handshake_2),
    .timeout_clr     (timeout_clr),
    .grant           (grant),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .timeout_master  (timeout_master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] done;
    logic [1:0] exp_grant;
    logic       exp_busy;
  } vec_t;

  vec_t       vecs[22];
  logic [1:0] rr_exp[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int bad;

    vecs[0]  = '{2'b00, 2'b00, 2'b00, 1'b0};
    vecs[1]  = '{2'b01, 2'b00, 2'b01, 1'b1};
    vecs[2]  = '{2'b01, 2'b00, 2'b01, 1'b1};
    vecs[3]  = '{2'b01, 2'b01, 2'b00, 1'b1};
    vecs[4]  = '{2'b00, 2'b00, 2'b00, 1'b0};
    vecs[5]  = '{2'b11, 2'b00, 2'b10, 1'b1};
    vecs[6]  = '{2'b11, 2'b10, 2'b00, 1'b1};
    vecs[7]  = '{2'b11, 2'b00, 2'b00, 1'b0};
    vecs[8]  = '{2'b11, 2'b00, 2'b01, 1'b1};
    vecs[9]  = '{2'b11, 2'b10, 2'b01, 1'b1};
    vecs[10] = '{2'b10, 2'b00, 2'b00, 1'b1};
    vecs[11] = '{2'b10, 2'b00, 2'b00, 1'b0};
    vecs[12] = '{2'b10, 2'b00, 2'b10, 1'b1};
    vecs[13] = '{2'b10, 2'b00, 2'b10, 1'b1};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 1'b1};
    vecs[15] = '{2'b00, 2'b00, 2'b00, 1'b0};
    vecs[16] = '{2'b01, 2'b00, 2'b01, 1'b1};
    vecs[17] = '{2'b01, 2'b01, 2'b00, 1'b1};
    vecs[18] = '{2'b01, 2'b00, 2'b00, 1'b0};
    vecs[19] = '{2'b01, 2'b00, 2'b01, 1'b1};
    vecs[20] = '{2'b00, 2'b00, 2'b00, 1'b1};
    vecs[21] = '{2'b00, 2'b00, 2'b00, 1'b0};

    rr_exp = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
               2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

    reset           = 1'b1;
    req             = 2'b00;
    done            = 2'b00;
    bus_handshake_1 = 1'b0;
    bus_handshake_2 = 1'b0;
    timeout_clr     = 1'b0;
    #1;
    check("reset_grant", grant, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_err", timeout_err, 1'b0);
    check("reset_master", timeout_master, 1'b0);
    tick;
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick;
      check($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_err", i), timeout_err, 1'b0);
    end
    done = 2'b00;

    // asynchronous reset in the middle of a grant
    req = 2'b10;
    tick;
    check("pre_async_grant", grant, 2'b10);
    #2 reset = 1'b1;
    req = 2'b00;
    #1;
    check("async_reset_grant", grant, 2'b00);
    check("async_reset_busy", busy, 1'b0);
    #2 reset = 1'b0;
    tick;
    check("post_reset_edge1", grant, 2'b00);
    req = 2'b10;
    tick;
    check("post_reset_edge2", grant, 2'b10);
    req = 2'b00;
    tick;
    tick;

    // round-robin with both masters requesting, done pulsed by the owner
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    req = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick;
      done = 2'b00;
      check($sformatf("rr%0d_grant", k), grant, rr_exp[k]);
      if (grant == 2'b11) check("rr_onehot", grant, 2'b00);
      done = grant;
    end
    done = 2'b00;
    req  = 2'b00;
    tick;
    tick;
    tick;

`ifdef BUS_TIMEOUT_EN
    // forced release of master 1 after 16 grant cycles
    req = 2'b10;
    tick;
    n = 0;
    while (grant == 2'b10 && n < 40) begin
      n++;
      tick;
    end
    req = 2'b00;
    check("to_grant_cycles", n, 16);
    check("to_grant_dropped", grant, 2'b00);
    check("to_err_set", timeout_err, 1'b1);
    check("to_master", timeout_master, 1'b1);
    tick;
    check("to_err_sticky", timeout_err, 1'b1);
    timeout_clr = 1'b1;
    tick;
    timeout_clr = 1'b0;
    check("to_err_cleared", timeout_err, 1'b0);
    tick;

    // done coincident with the expiring cycle wins
    req = 2'b01;
    tick;
    for (int k = 0; k < 15; k++) tick;
    check("tie_still_granted", grant, 2'b01);
    done = 2'b01;
    tick;
    done = 2'b00;
    req  = 2'b00;
    check("tie_grant", grant, 2'b00);
    check("tie_err", timeout_err, 1'b0);
    tick;
    tick;

    // periodic handshake_2 edges keep the watchdog from firing
    req = 2'b01;
    tick;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      bus_handshake_2 = (i % 10 == 5);
      tick;
      if (grant != 2'b01) bad++;
    end
    bus_handshake_2 = 1'b0;
    check("hs2_no_drop", bad, 0);
    check("hs2_no_err", timeout_err, 1'b0);
    done = 2'b01;
    tick;
    done = 2'b00;
    req  = 2'b00;
    check("hs2_done_grant", grant, 2'b00);
    tick;
`else
    // without the watchdog a grant is held indefinitely
    req = 2'b01;
    tick;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      timeout_clr = (i == 20);
      tick;
      if (grant != 2'b01 || timeout_err != 1'b0 || timeout_master != 1'b0) bad++;
    end
    timeout_clr = 1'b0;
    check("nowd_hold", bad, 0);
    done = 2'b01;
    tick;
    done = 2'b00;
    req  = 2'b00;
    check("nowd_done_grant", grant, 2'b00);
    check("nowd_done_busy", busy, 1'b1);
    tick;
    check("nowd_idle_busy", busy, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
